led_pulse_driver: RTL
=====================

# led_pulse_driver

Drives an active-low indicator output (LED, buzzer or relay pin) with a burst of N timed ON/OFF pulses per request. It is the output-side counterpart of the switch debouncer. Control logic issues a one-cycle start with a pulse count. The block generates the timed waveform on the pin and reports completion. It sits between the panel control FSM and the board's indicator pins, one instance per output.

## Interface
- PRESCALE, 50000: clk cycles per tick; must be ≥ 1.
- ON_TICKS, 8: ticks the output stays active per pulse; must be ≥ 1.
- OFF_TICKS, 8: ticks the output stays inactive after each pulse; must be ≥ 1.
- CNT_W, 4: width of the pulse-count input.
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request; honoured only when busy=0.
- count  input  CNT_W  number of pulses; sampled in the start cycle.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle strobe when a burst completes.
- ledout_n  output  1  pin drive, inverted (0 = ON, 1 = OFF).
- abort  input  1  present only with LED_PULSE_ABORT_EN.

## Operation
- States:
  - IDLE → ON: start && count≠0.
  - IDLE → FIN: start && count=0.
  - ON → OFF: after ON_TICKS ticks.
  - OFF → ON: after OFF_TICKS ticks, if pulses remain.
  - OFF → FIN: after OFF_TICKS ticks, if this was the last pulse.
  - FIN → IDLE: unconditionally, after 1 cycle.
- Reset values:
  - State IDLE.
  - ledout_n=1, busy=0, done=0.
  - Prescaler and all counters at 0.
- Prescaler:
  - Restarts at 0 on every accepted start and on every phase change.
  - Tick = prescaler reaching PRESCALE−1, then wraps to 0.
  - Each phase therefore lasts exactly ticks×PRESCALE cycles.
- Pulse counter:
  - Loaded with count on accept.
  - Decremented on each ON→OFF transition.
  - The "last pulse" decision is made on the decremented value.
- start while busy=1 (including in the FIN cycle) is ignored; no queuing.
- Maximum count (2^CNT_W−1) is supported; the counter never wraps.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Start accepted at cycle t:
  - busy=1 from t+1.
  - ledout_n=0 from t+1.
- ON phase covers cycles t+1 … t+ON_TICKS×PRESCALE.
- OFF phase follows for OFF_TICKS×PRESCALE cycles.
- Burst of N pulses: done=1 for one cycle at t+1+N×(ON_TICKS+OFF_TICKS)×PRESCALE.
  - busy is still 1 in that cycle and falls to 0 on the next cycle.
- count=0: done=1 at t+1, busy=1 only at t+1; ledout_n stays 1.
- Earliest next start is accepted in the cycle busy reads 0.
- rst mid-burst: on the next edge, all outputs return to reset values; no done is issued.

## Configuration
- LED_PULSE_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in any non-IDLE state forces IDLE on the next edge: ledout_n=1, busy=0, no done strobe.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect.
- LED_PULSE_ABORT_EN undefined: no abort port; a burst always runs to completion or to rst.

## Structure
- Shared package led_pulse_pkg holds:
  - The state enum (IDLE, ON, OFF, FIN).
  - A localparam function for the prescaler width ($clog2(PRESCALE)).
- Sub-module tick_gen:
  - Parameterised prescaler with inputs clear and enable.
  - Output tick, a one-cycle strobe.
  - Reused by other timed-output blocks.

## Test plan
Bench parameters: PRESCALE=4, ON_TICKS=2, OFF_TICKS=3, CNT_W=4.
- Single pulse: start at t with count=1.
  - ledout_n=0 for t+1…t+8, then 1.
  - done strobes at t+21; busy falls at t+22.
- Burst: count=3.
  - Exactly 3 low windows of 8 cycles, separated by 12 high cycles.
  - done at t+61.
- Edge requests:
  - count=0 → done at t+1, ledout_n never low.
  - start pulsed at t+5 during a burst is ignored; the waveform is unchanged.
- Reset mid-burst: rst at t+10 of a count=2 burst.
  - ledout_n=1, busy=0 on the next cycle; no done.
  - A subsequent start behaves as from cold.
- Back-to-back: a new start in the first cycle with busy=0 after done.
  - Accepted; ledout_n low on the next cycle.
- With LED_PULSE_ABORT_EN:
  - abort at t+15 of a count=2 burst → idle at t+16, no done.
  - abort together with start in IDLE → the start is accepted (abort has no effect in IDLE).

Source files
------------

// File: rtl/led_pulse_pkg.sv
// Shared types and helpers for the timed indicator-output blocks.
package led_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Counter width able to hold 0 .. v-1; never narrower than one bit.
    function automatic int presc_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/led_pulse_driver_tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick every PRESCALE
// enabled cycles; clear restarts the count at 0.
module tick_gen
    import led_pulse_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int             W    = presc_width(PRESCALE);
    localparam logic [W-1:0]   LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Depends only on registered state so clear (derived from tick) cannot loop back.
    assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/led_pulse_driver.sv
// Burst generator for an active-low indicator pin: N timed ON/OFF pulses per start.
// Optional abort input enabled by defining LED_PULSE_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start, pin inactive
// ON    | pin active for ON_TICKS ticks
// OFF   | pin inactive for OFF_TICKS ticks
// FIN   | one-cycle completion strobe, still busy
module led_pulse_driver
    import led_pulse_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int ON_TICKS  = 8,
    parameter int OFF_TICKS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
`ifdef LED_PULSE_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             ledout_n_o
);

    localparam int            MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int            TW        = presc_width(MAX_TICKS);
    localparam logic [TW-1:0] ON_LOAD   = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LOAD  = TW'(OFF_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic [TW-1:0]    ticks_q, ticks_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             led_n_q, led_n_d;
    logic             tick;
    logic             presc_clear;
    logic             presc_en;

    assign presc_en    = (state_q == ON) || (state_q == OFF);
    assign presc_clear = (state_d != state_q);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (presc_clear),
        .enable_i (presc_en),
        .tick_o   (tick)
    );

    always_comb begin
        state_d  = state_q;
        pulses_d = pulses_q;
        ticks_d  = ticks_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pulses_d = count_i;
                    if (count_i != '0) begin
                        state_d = ON;
                        ticks_d = ON_LOAD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            ON: begin
                if (tick) begin
                    if (ticks_q == '0) begin
                        state_d  = OFF;
                        ticks_d  = OFF_LOAD;
                        pulses_d = pulses_q - 1'b1;
                    end else begin
                        ticks_d = ticks_q - 1'b1;
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    if (ticks_q == '0) begin
                        // pulses_q already holds the post-decrement remaining count
                        if (pulses_q == '0) begin
                            state_d = FIN;
                        end else begin
                            state_d = ON;
                            ticks_d = ON_LOAD;
                        end
                    end else begin
                        ticks_d = ticks_q - 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef LED_PULSE_ABORT_EN
        if (abort_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            pulses_d = '0;
            ticks_d  = '0;
        end
`endif
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        led_n_d = (state_d != ON);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pulses_q <= '0;
            ticks_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            led_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            pulses_q <= pulses_d;
            ticks_q  <= ticks_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            led_n_q  <= led_n_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign ledout_n_o = led_n_q;

endmodule
